// File: rtl/instr_fetch_if.sv
// Fetch unit signal bundle: control-unit redirect, instruction-memory read port and
// decoder handoff. The master modport is the fetch unit's view.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    input  redirect,
    input  redirect_pc,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect,
    output redirect_pc,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory reads into a 2-entry prefetch FIFO.
// Optional decoder-starve counter enabled by the FETCH_STALL_CNT_EN macro.
module instr_fetch #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus,
  output logic [15:0]    stall_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFlushWait
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  logic [1:0][DATA_W-1:0] fifo_instr_q;
  logic [1:0][ADDR_W-1:0] fifo_pc_q;
  logic                   rd_ptr_q, wr_ptr_q;
  logic [1:0]             count_q, count_d;
  logic [1:0]             count_push;

  logic instr_valid;
  logic ack;
  logic push;
  logic pop;

  assign instr_valid = (count_q != 2'd0);
  // An ack with no request on the bus is not ours to consume.
  assign ack         = bus.mem_ack & mem_req_q;
  // A redirect flushes the head, so a same-cycle accept never counts as a pop.
  assign pop         = instr_valid & bus.instr_ready & ~bus.redirect;
  assign count_push  = count_q + 2'd1 - {1'b0, pop};

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = StReq;
        end else if (count_q < 2'd2) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          // Without the ack the old read is still in flight and must be drained.
          state_d    = ack ? StReq : StFlushWait;
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          state_d    = (count_push < 2'd2) ? StReq : StIdle;
        end
      end
      StFlushWait: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end
        if (ack) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    mem_req_d = (state_d != StIdle);
    // FlushWait keeps presenting the abandoned address until its ack arrives.
    if (state_d == StReq) begin
      mem_addr_d = fetch_pc_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.redirect) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_instr_q <= '0;
      fifo_pc_q    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
    end else if (bus.redirect) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= bus.mem_rdata;
        fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (bus.instr_ready && !instr_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_instr_fetch;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] stall_cnt;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a ^ 16'hC3A5) + 16'h0111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of delivered words plus the single in-flight request.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        m_q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_addr;
  bit            m_req;
  bit            m_discard;
  int unsigned   m_stall;

  task automatic model_reset();
    m_q.delete();
    m_pc      = '0;
    m_addr    = '0;
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_stall   = 0;
  endtask

  task automatic model_step(input bit redir, input logic [AW-1:0] rpc, input bit ready,
                            input bit ack, input logic [DW-1:0] rdata);
    int unsigned held;
    held = m_q.size();
    if (ready && held == 0 && m_stall < 32'hFFFF) m_stall++;
    if (redir) begin
      m_q.delete();
      m_pc = rpc;
      if (m_req && !ack) begin
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0;
        m_req     = 1'b1;
        m_addr    = m_pc;
      end
    end else begin
      if (ready && held > 0) void'(m_q.pop_front());
      if (m_req && ack) begin
        if (!m_discard) begin
          m_q.push_back('{data: rdata, pc: m_pc});
          m_pc = m_pc + 16'd1;
        end
        m_discard = 1'b0;
        m_req     = (m_q.size() < 2);
        m_addr    = m_pc;
      end else if (!m_req && held < 2) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  function automatic logic [15:0] exp_stall();
`ifdef FETCH_STALL_CNT_EN
    return 16'(m_stall);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(m_req));
    if (m_req) chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(m_addr));
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk({tag, ".instr_pc"}, 32'(bus.instr_pc), 32'(m_q[0].pc));
      chk({tag, ".instr"}, 32'(bus.instr), 32'(m_q[0].data));
    end
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall()));
  endtask

  // Memory side: ack after `lat` request cycles, or a coin flip when rand_ack is set.
  int unsigned lat      = 1;
  int unsigned wait_cnt = 0;
  bit          rand_ack = 1'b0;
  int unsigned n_reads  = 0;

  task automatic apply(input bit redir, input logic [AW-1:0] rpc, input bit ready, input bit ack);
    logic [DW-1:0] rd;
    bit            req_before;
    rd              = mem_word(bus.mem_addr);
    req_before      = bus.mem_req;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.instr_ready = ready;
    bus.mem_ack     = ack;
    bus.mem_rdata   = rd;
    @(posedge clk);
    model_step(redir, rpc, ready, ack, rd);
    if (req_before && ack) n_reads++;
    wait_cnt = (req_before && !ack) ? wait_cnt + 1 : 0;
    #1;
    check_model("model");
  endtask

  task automatic tick(input bit redir, input logic [AW-1:0] rpc, input bit ready);
    bit ack;
    if (rand_ack) ack = 1'($urandom_range(0, 1));
    else          ack = bus.mem_req && (wait_cnt + 1 >= lat);
    apply(redir, rpc, ready, ack);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.instr_ready = 1'b0;
    model_reset();
    wait_cnt = 0;
    n_reads  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("reset");
  endtask

  typedef struct {
    bit          redir;
    logic [15:0] rpc;
    bit          ready;
    bit          ack;
    bit          e_req;
    logic [15:0] e_addr;
    bit          e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic run_random();
    bit          r;
    bit          rdy;
    logic [15:0] rpc;
    do_reset();
    for (int blk = 0; blk < 16; blk++) begin
      lat      = $urandom_range(1, 4);
      rand_ack = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 150; c++) begin
        r   = ($urandom_range(0, 11) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) rpc = 16'hFFFE + 16'($urandom_range(0, 1));
        else                           rpc = 16'($urandom);
        tick(r, rpc, rdy);
      end
    end
    rand_ack = 1'b0;
  endtask

  initial begin
    //                redir  rpc     rdy   ack   req   addr    valid pc
    vecs[0]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0};
    vecs[1]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h0,  1'b0, 16'h0};
    vecs[2]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h1,  1'b1, 16'h0};
    vecs[3]  = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h2,  1'b1, 16'h1};
    vecs[4]  = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 16'h3,  1'b1, 16'h2};
    vecs[5]  = '{1'b0, 16'h0,  1'b0, 1'b1, 1'b1, 16'h3,  1'b1, 16'h2};
    vecs[6]  = '{1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 16'h0,  1'b1, 16'h2};
    vecs[7]  = '{1'b0, 16'h0,  1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h2};
    vecs[8]  = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 16'h3};
    vecs[9]  = '{1'b1, 16'h40, 1'b1, 1'b1, 1'b1, 16'h4,  1'b1, 16'h3};
    vecs[10] = '{1'b0, 16'h0,  1'b1, 1'b0, 1'b1, 16'h40, 1'b0, 16'h0};
    vecs[11] = '{1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h40, 1'b0, 16'h0};
    vecs[12] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 16'h41, 1'b1, 16'h40};

    // Reset state and directed vector table
    do_reset();
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst.instr", 32'(bus.instr), 32'h0);
    chk("rst.instr_pc", 32'(bus.instr_pc), 32'h0);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d.mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d.instr_pc", i), 32'(bus.instr_pc), 32'(vecs[i].e_pc));
        chk($sformatf("vec%0d.instr", i), 32'(bus.instr), 32'(mem_word(vecs[i].e_pc)));
      end
      apply(vecs[i].redir, vecs[i].rpc, vecs[i].ready, vecs[i].ack);
    end

    // Decoder stalled, zero-wait memory: fill both slots then stop requesting
    do_reset();
    lat = 1;
    repeat (10) tick(1'b0, 16'h0, 1'b0);
    chk("full.reads", 32'(n_reads), 32'd2);
    chk("full.mem_req", 32'(bus.mem_req), 32'd0);
    chk("full.instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("full.instr_pc", 32'(bus.instr_pc), 32'h0);

    // Redirect while a 3-cycle read is in flight
    do_reset();
    apply(1'b0, 16'h0, 1'b1, 1'b0);
    apply(1'b0, 16'h0, 1'b1, 1'b0);
    apply(1'b1, 16'h40, 1'b1, 1'b0);
    chk("flush.old_addr", 32'(bus.mem_addr), 32'h0);
    chk("flush.old_req", 32'(bus.mem_req), 32'd1);
    apply(1'b0, 16'h0, 1'b1, 1'b1);
    chk("flush.new_addr", 32'(bus.mem_addr), 32'h40);
    chk("flush.dropped", 32'(bus.instr_valid), 32'd0);
    apply(1'b0, 16'h0, 1'b1, 1'b1);
    chk("flush.first_pc", 32'(bus.instr_pc), 32'h40);
    chk("flush.first_valid", 32'(bus.instr_valid), 32'd1);

    // PC wrap from 0xFFFF
    do_reset();
    lat = 1;
    apply(1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    chk("wrap.pc0", 32'(bus.instr_pc), 32'hFFFF);
    tick(1'b0, 16'h0, 1'b1);
    chk("wrap.pc1", 32'(bus.instr_pc), 32'h0000);

    // Asynchronous reset with a read outstanding at 0x0005
    do_reset();
    apply(1'b1, 16'h4, 1'b0, 1'b0);
    apply(1'b0, 16'h0, 1'b0, 1'b1);
    apply(1'b0, 16'h0, 1'b0, 1'b0);
    chk("arst.pre_addr", 32'(bus.mem_addr), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("arst.mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("arst.instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst.instr", 32'(bus.instr), 32'h0);
    chk("arst.instr_pc", 32'(bus.instr_pc), 32'h0);
    chk("arst.stall_cnt", 32'(stall_cnt), 32'h0);
    do_reset();
    lat = 1;
    tick(1'b0, 16'h0, 1'b0);
    chk("arst.first_req", 32'(bus.mem_req), 32'd1);
    chk("arst.first_addr", 32'(bus.mem_addr), 32'h0);

    // Decoder starving behind 4-cycle memory
    do_reset();
    lat = 4;
    repeat (20) tick(1'b0, 16'h0, 1'b1);
    chk("stall.final", 32'(stall_cnt), 32'(exp_stall()));

    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
